dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the MEM-stage load/store requests of the MIPS pipeline (`MemRead`, `MemWrite`, ALU-result address, rt write data). It is the memory side of the MEM-stage interface. It accepts one word request at a time and holds the pipeline with `stall` for a programmable number of wait cycles. It returns registered read data with a one-cycle `done` pulse. It also mirrors two fixed memory words on `out1` and `out2` for board and bench observation.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two; `AW = $clog2(DEPTH)`.
- `LATENCY`, 2: number of stall cycles per access; legal range 1..15.
- `OUT1_ADDR`, 0: word index mirrored on `out1`.
- `OUT2_ADDR`, 1: word index mirrored on `out2`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request from the MEM stage.
- `MemWrite`  in  1  store request from the MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (rt value).
- `read_data`  out  32  registered load data; held until the next load completes.
- `stall`  out  1  freezes PC, IF2ID, ID2EXE, EXE2MEM and MEM2WB while high.
- `done`  out  1  one-cycle pulse in the response cycle.
- `err`  out  1  one-cycle pulse on a rejected request.
- `out1`, `out2`  out  32  live copies of `mem[OUT1_ADDR]` and `mem[OUT2_ADDR]`.

## Operation
- States: IDLE, WAIT, RESP.
- A request is valid when `MemRead ^ MemWrite` is high and `address[1:0] == 0`.
- A request is rejected when `MemRead & MemWrite` is high, or when it is misaligned with either strobe high.
  - `err` pulses in the cycle the request is seen.
  - No access occurs, `stall` stays low, and the state remains IDLE.
- Word index = `address[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- IDLE with a valid request (accept):
  - Capture the op, index and `write_data`.
  - `stall` = 1 combinationally in this cycle.
  - If `LATENCY == 1`, go to RESP. Otherwise load `cnt = LATENCY-2` and go to WAIT.
- WAIT: `stall` = 1.
  - If `cnt == 0`, go to RESP. Otherwise decrement `cnt`.
- On the edge entering RESP:
  - A store writes `mem[idx]`.
  - A load loads `read_data`.
- RESP: `stall` = 0 and `done` = 1. The pipeline advances at the end of this cycle. Next state is IDLE.
- After RESP, IDLE evaluates the new MEM-stage request in the following cycle. Back-to-back accesses therefore cost `LATENCY+1` cycles each.
- Once captured, an access completes. Dropping or changing `MemRead`/`MemWrite` in WAIT has no effect; only the captured values are used.
- `stall` is a function of state and the current request only. It has no path from `read_data`.

## Timing
- Reset values: state IDLE, `cnt` 0, `read_data` 0, `stall` 0, `done` 0, `err` 0, all memory words 0. Consequently `out1` and `out2` are 0.
- Accept at cycle T:
  - `stall` is high in cycles T .. T+LATENCY-1.
  - `done` is high and `read_data` is valid at T+LATENCY.
  - Store data is visible on `out1`/`out2` at T+LATENCY.
- `rst` asserted at any point before the RESP edge aborts the access:
  - No write commits.
  - The state machine returns to IDLE on the next edge.
- `err` and `done` never assert in the same cycle.
- `err` and `stall` never assert in the same cycle.

## Structure
- `mips_pkg` holds:
  - the `dmem_state_t` enum {IDLE, WAIT, RESP};
  - `WORD_W = 32`;
  - the `DMEM_LAT_MAX = 15` constant.
- One sub-module, `data_mem_array`:
  - `DEPTH`×32 storage with synchronous write port and synchronous clear;
  - one read port;
  - two fixed observation ports.
- The FSM, counter and request capture stay in `dmem_responder`.

## Test plan
- Reset, then store `0xDEADBEEF` to address `0x0`:
  - `stall` is high for 2 cycles.
  - `done` pulses at T+2.
  - `out1 = 0xDEADBEEF` from T+2.
- Store `0x12345678` to `0x404` with `DEPTH = 256` (wraps to index 1), then load `0x4`:
  - `out2 = 0x12345678`.
  - The load returns `read_data = 0x12345678` at T+2.
- Request with `address = 0x6`, or with `MemRead = MemWrite = 1`:
  - `err` pulses once, `stall` stays 0, and memory is unchanged.
- `LATENCY = 1` and `LATENCY = 5` builds:
  - `stall` widths are 1 and 5 respectively.
  - Back-to-back loads complete every 2 and 6 cycles.
- Drop `MemWrite` during WAIT:
  - The store still commits.
  - `done` still pulses at T+LATENCY.
- Assert `rst` in the WAIT cycle of a store to `0x0`:
  - `out1` stays 0.
  - The next cycle is IDLE with all outputs 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MEM-stage data-memory responder.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       : data word width
//   DMEM_LAT_MAX : largest supported stall latency
package mips_pkg;

  localparam int WORD_W       = 32;
  localparam int DMEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x WORD_W word storage.
//   clk_i    : clock
//   clr_i    : synchronous clear of every word (wins over a write)
//   we_i     : write enable, word idx_i <= wdata_i on the rising edge
//   idx_i    : word index shared by the write and read ports
//   wdata_i  : write data
//   rdata_o  : combinational read of word idx_i
//   obs1_o   : live copy of word OUT1_ADDR
//   obs2_o   : live copy of word OUT2_ADDR
module data_mem_array
  import mips_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int OUT1_ADDR = 0,
  parameter int OUT2_ADDR = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [WORD_W-1:0] obs1_o,
  output logic [WORD_W-1:0] obs2_o
);

  localparam logic [AW-1:0] O1 = AW'(OUT1_ADDR);
  localparam logic [AW-1:0] O2 = AW'(OUT2_ADDR);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];
  assign obs1_o  = mem_q[O1];
  assign obs2_o  = mem_q[O2];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word memory behind the MIPS MEM stage.
// Accepts one aligned load or store at a time, holds the pipeline with
// stall for LATENCY cycles (legal 1..DMEM_LAT_MAX), then pulses done with
// registered read data. Bad requests pulse err and are dropped.
//   clk, rst             : clock, synchronous active-high reset
//   MemRead, MemWrite    : load / store strobes from the MEM stage
//   address, write_data  : byte address (ALU result), store data (rt)
//   read_data            : last completed load, held between loads
//   stall                : pipeline freeze while an access is in flight
//   done                 : one-cycle pulse in the response cycle
//   err                  : one-cycle pulse on a rejected request
//   out1, out2           : live copies of mem[OUT1_ADDR], mem[OUT2_ADDR]
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2,
  parameter int OUT1_ADDR = 0,
  parameter int OUT2_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       out1,
  output logic [31:0]       out2
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DMEM_LAT_MAX + 1);
  localparam bit LAT1     = (LATENCY == 1);
  localparam int WAIT_CNT = (LATENCY > 1) ? LATENCY - 2 : 0;

  dmem_state_t       state_q;
  logic [CW-1:0]     cnt_q;
  logic              op_wr_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              done_q;

  logic              req_valid, req_reject, accept;
  logic              fast_commit, commit, commit_wr;
  logic [AW-1:0]     commit_idx, req_idx;
  logic [WORD_W-1:0] commit_data, mem_rdata;
  logic              unused_addr;

  // Upper address bits wrap the index modulo DEPTH.
  assign req_idx     = address[AW+1:2];
  assign unused_addr = ^{address[31:AW+2]};

  // Anything with a strobe that is not a clean single aligned op is rejected.
  assign req_valid  = (MemRead ^ MemWrite) & (address[1:0] == 2'b00);
  assign req_reject = (MemRead | MemWrite) & ~req_valid;
  assign accept     = (state_q == IDLE) & req_valid;

  // Requests are only looked at in IDLE; WAIT/RESP ignore the live strobes.
  assign stall = accept | (state_q == WAIT);
  assign err   = (state_q == IDLE) & req_reject;
  assign done  = done_q;
  assign read_data = rdata_q;

  // The access commits on the edge entering RESP. With LATENCY==1 that is
  // the accept edge itself, so the op comes straight from the inputs.
  // Reset on that edge suppresses the commit.
  assign fast_commit = LAT1 & accept;
  assign commit      = ~rst & (fast_commit | ((state_q == WAIT) & (cnt_q == '0)));
  assign commit_wr   = fast_commit ? MemWrite   : op_wr_q;
  assign commit_idx  = fast_commit ? req_idx    : idx_q;
  assign commit_data = fast_commit ? write_data : wdata_q;

  data_mem_array #(
    .DEPTH     (DEPTH),
    .OUT1_ADDR (OUT1_ADDR),
    .OUT2_ADDR (OUT2_ADDR)
  ) u_mem (
    .clk_i   (clk),
    .clr_i   (rst),
    .we_i    (commit & commit_wr),
    .idx_i   (commit_idx),
    .wdata_i (commit_data),
    .rdata_o (mem_rdata),
    .obs1_o  (out1),
    .obs2_o  (out2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (commit && !commit_wr) rdata_q <= mem_rdata;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_wr_q <= MemWrite;
            idx_q   <= req_idx;
            wdata_q <= write_data;
            if (LAT1) begin
              state_q <= RESP;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= CW'(WAIT_CNT);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          drop;     // release the strobe during WAIT
    logic [31:0] addr;
    logic [31:0] wd;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_out1;
    logic [31:0] exp_out2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // main DUT (LATENCY = 2)
  logic        rd, wr;
  logic [31:0] addr, wd, rdata, o1, o2;
  logic        stall, done, err;
  // LATENCY = 1 / 5 DUTs share a load-only stimulus
  logic        lrd;
  logic [31:0] laddr;
  logic [31:0] rdata1, o11, o21, rdata5, o15, o25;
  logic        stall1, done1, err1, stall5, done5, err5;

  int checks = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2), .OUT1_ADDR(0), .OUT2_ADDR(1)) dut (
    .clk(clk), .rst(rst), .MemRead(rd), .MemWrite(wr), .address(addr),
    .write_data(wd), .read_data(rdata), .stall(stall), .done(done), .err(err),
    .out1(o1), .out2(o2));

  dmem_responder #(.DEPTH(256), .LATENCY(1), .OUT1_ADDR(0), .OUT2_ADDR(1)) dut1 (
    .clk(clk), .rst(rst), .MemRead(lrd), .MemWrite(1'b0), .address(laddr),
    .write_data(32'h0), .read_data(rdata1), .stall(stall1), .done(done1), .err(err1),
    .out1(o11), .out2(o21));

  dmem_responder #(.DEPTH(256), .LATENCY(5), .OUT1_ADDR(0), .OUT2_ADDR(1)) dut5 (
    .clk(clk), .rst(rst), .MemRead(lrd), .MemWrite(1'b0), .address(laddr),
    .write_data(32'h0), .read_data(rdata5), .stall(stall5), .done(done5), .err(err5),
    .out1(o15), .out2(o25));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit w, bit dr, logic [31:0] a, logic [31:0] d, bit e,
                              logic [31:0] xr, logic [31:0] x1, logic [31:0] x2);
    vec_t v;
    v.rd = r; v.wr = w; v.drop = dr; v.addr = a; v.wd = d; v.exp_err = e;
    v.exp_rdata = xr; v.exp_out1 = x1; v.exp_out2 = x2;
    return v;
  endfunction

  // One request on the LATENCY=2 DUT, from IDLE back to IDLE.
  task automatic run_txn(input int k, input vec_t v);
    int  n;
    int  st;
    bit  got;
    @(negedge clk);
    rd = v.rd; wr = v.wr; addr = v.addr; wd = v.wd;
    #1;
    if (v.exp_err) begin
      check($sformatf("v%0d_err", k), err, 1);
      check($sformatf("v%0d_err_stall", k), stall, 0);
      check($sformatf("v%0d_err_done", k), done, 0);
    end else begin
      n = 0; st = 0; got = 0;
      while (!got && n < 20) begin
        check($sformatf("v%0d_no_err_c%0d", k, n), err, 0);
        if (stall) st++;
        if (done) got = 1;
        else begin
          @(negedge clk);
          n++;
          if (v.drop && n == 1) begin rd = 0; wr = 0; end
          #1;
        end
      end
      check($sformatf("v%0d_done_seen", k), got, 1);
      check($sformatf("v%0d_latency", k), n, 2);
      check($sformatf("v%0d_stall_width", k), st, 2);
      check($sformatf("v%0d_stall_in_resp", k), stall, 0);
    end
    check($sformatf("v%0d_read_data", k), rdata, v.exp_rdata);
    check($sformatf("v%0d_out1", k), o1, v.exp_out1);
    check($sformatf("v%0d_out2", k), o2, v.exp_out2);
    rd = 0; wr = 0;
    @(negedge clk);
    #1;
    check($sformatf("v%0d_after_done", k), done, 0);
    check($sformatf("v%0d_after_err", k), err, 0);
    check($sformatf("v%0d_after_stall", k), stall, 0);
    check($sformatf("v%0d_after_out1", k), o1, v.exp_out1);
    check($sformatf("v%0d_after_out2", k), o2, v.exp_out2);
  endtask

  vec_t vecs[13];

  initial begin
    //              rd wr dr addr          wd            err rdata         out1          out2
    vecs[0]  = mk(0, 1, 0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'h0,        32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0000_0404, 32'h1234_5678, 0, 32'h0,        32'hDEAD_BEEF, 32'h1234_5678);
    vecs[2]  = mk(1, 0, 0, 32'h0000_0004, 32'h0,         0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[3]  = mk(1, 0, 0, 32'h0000_0000, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[4]  = mk(0, 1, 0, 32'h0000_0006, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[5]  = mk(1, 1, 0, 32'h0000_0000, 32'h0,         1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[6]  = mk(1, 0, 0, 32'h0000_0001, 32'h0,         1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[7]  = mk(0, 1, 0, 32'h0000_0008, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[8]  = mk(1, 0, 0, 32'h0000_0008, 32'h0,         0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[9]  = mk(1, 0, 0, 32'h0000_0404, 32'h0,         0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[10] = mk(1, 0, 0, 32'hFFFF_FC08, 32'h0,         0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[11] = mk(0, 1, 1, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h1234_5678);
    vecs[12] = mk(1, 0, 0, 32'h0000_0000, 32'h0,         0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678);

    rst = 1; rd = 0; wr = 0; addr = 0; wd = 0; lrd = 0; laddr = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("reset_stall", stall, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_read_data", rdata, 0);
    check("reset_out1", o1, 0);
    check("reset_out2", o2, 0);

    // Back-to-back loads: LATENCY=1 completes every 2 cycles, LATENCY=5 every 6.
    @(negedge clk);
    lrd = 1; laddr = 32'h0;
    for (int c = 0; c < 24; c++) begin
      #1;
      check($sformatf("lat1_done_c%0d", c), done1, (c % 2 == 1));
      check($sformatf("lat1_stall_c%0d", c), stall1, (c % 2 != 1));
      check($sformatf("lat5_done_c%0d", c), done5, (c % 6 == 5));
      check($sformatf("lat5_stall_c%0d", c), stall5, (c % 6 != 5));
      check($sformatf("lat_err_c%0d", c), err1 | err5, 0);
      @(negedge clk);
    end
    lrd = 0;
    repeat (6) @(negedge clk);
    #1;
    check("lat_idle_stall", stall1 | stall5, 0);

    for (int k = 0; k < 13; k++) run_txn(k, vecs[k]);

    // Reset during the WAIT cycle of a store aborts it.
    @(negedge clk);
    wr = 1; addr = 32'h0; wd = 32'h7777_7777;
    #1;
    check("abort_accept_stall", stall, 1);
    @(negedge clk);
    wr = 0; rst = 1;
    #1;
    check("abort_wait_stall", stall, 1);
    @(negedge clk);
    rst = 0;
    #1;
    check("abort_out1", o1, 0);
    check("abort_out2", o2, 0);
    check("abort_stall", stall, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_read_data", rdata, 0);
    @(negedge clk);
    #1;
    check("abort_no_late_done", done, 0);
    check("abort_out1_later", o1, 0);

    // Normal operation resumes after the abort.
    run_txn(20, mk(0, 1, 0, 32'h0000_0004, 32'h5555_AAAA, 0, 32'h0, 32'h0, 32'h5555_AAAA));
    run_txn(21, mk(1, 0, 0, 32'h0000_0004, 32'h0, 0, 32'h5555_AAAA, 32'h0, 32'h5555_AAAA));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
